fpga_input_conditioner: RTL
===========================

FPGA_INPUT_CONDITIONER -- requirements
Module: fpga_input_conditioner

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 12, the number of raw board switches and buttons conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20000, the stable-cycle count required before a level change (legal range >=1).
REQ-003 SHALL have parameter RESET_HOLD_CYCLES, default 1024, the number of cycles soc_rst_no stays low after reset release (legal range >=1).
REQ-004 SHALL have port ref_clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port pad_reset, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have port raw_i, input, NUM_INPUTS, asynchronous switch/button pins.
REQ-007 SHALL have port rst_btn_i, input, 1, asynchronous user reset button, active-high.
REQ-008 SHALL have port level_o, output, NUM_INPUTS, debounced levels.
REQ-009 SHALL have port rise_o, output, NUM_INPUTS, one-cycle pulses on a debounced 0->1 change.
REQ-010 SHALL have port fall_o, output, NUM_INPUTS, one-cycle pulses on a debounced 1->0 change.
REQ-011 SHALL have port soc_rst_no, output, 1, active-low SoC reset, asserted asynchronously and released synchronously.

Function
REQ-012 SHALL pass each raw_i bit and rst_btn_i through a 2-flop synchronizer.
REQ-013 SHALL keep a saturating counter per channel that increments while the synchronized value differs from level_o and clears to 0 on any cycle where they match, never wrapping.
REQ-014 SHALL toggle level_o on the edge at which the mismatch has persisted for DEBOUNCE_CYCLES consecutive cycles, clearing the counter on that same edge.
REQ-015 SHALL give a stable raw change a latency of 2+DEBOUNCE_CYCLES edges to level_o.
REQ-016 SHALL NOT change level_o, rise_o or fall_o for a glitch shorter than DEBOUNCE_CYCLES synchronized cycles.
REQ-017 SHALL register rise_o and fall_o together with level_o so each is high exactly in the first cycle the new level is visible, never both high at once.
REQ-018 SHALL condition rst_btn_i with the same debounce channel logic, with its level internal only.
REQ-019 SHALL implement a reset FSM with states RESET, HOLD and RUN.
REQ-020 SHALL hold RESET while pad_reset is high, with soc_rst_no=0 and the hold counter at 0.
REQ-021 SHALL go RESET->HOLD on the first edge after synchronized pad_reset release.
REQ-022 SHALL keep soc_rst_no=0 in HOLD, count RESET_HOLD_CYCLES cycles, then go to RUN.
REQ-023 SHALL drive soc_rst_no=1 in RUN.
REQ-024 SHALL go RUN->HOLD on a debounced button level of 1, driving soc_rst_no to 0 on the same edge and clearing the hold counter.
REQ-025 SHALL hold the counter at 0 in HOLD while the debounced button level is 1, starting the count only after it returns to 0.
REQ-026 SHALL return to RESET asynchronously from any state when pad_reset is asserted mid-HOLD or mid-RUN.

Reset
REQ-027 SHALL assert pad_reset asynchronously into every flop and release it through an internal 2-flop reset synchronizer.
REQ-028 SHALL reset all synchronizers, counters, level_o, rise_o and fall_o to 0, soc_rst_no to 0, and the FSM to RESET.
REQ-029 SHALL power up inputs held high at reset as level_o=0, rising after the normal debounce latency with a rise_o pulse.

Structure
REQ-030 SHALL place the parameter defaults and the FSM state enum (RESET/HOLD/RUN) in shared package fpga_io_pkg.
REQ-031 SHALL implement per-channel synchronizer, counter and edge logic in one sub-module, fpga_debounce_ch, instantiated NUM_INPUTS+1 times.
REQ-032 SHALL size counter widths as $clog2(param+1).

Verification (NUM_INPUTS=4, DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8)
REQ-033 SHALL verify that releasing pad_reset with rst_btn_i=0 gives soc_rst_no=0 for 8 HOLD cycles, then 1, and stays 1.
REQ-034 SHALL verify that raw_i[0] 0->1 held 10 cycles sets level_o[0]=1 exactly 6 edges after first sampling, with rise_o[0] high for 1 cycle.
REQ-035 SHALL verify that a 3-cycle pulse on raw_i[1] leaves level_o[1]=0 with no rise_o or fall_o.
REQ-036 SHALL verify that in RUN, rst_btn_i high for 20 cycles drives soc_rst_no low 6 edges later, and that soc_rst_no rises 8 cycles after the debounced button level returns to 0.
REQ-037 SHALL verify that pad_reset pulsed at HOLD count 5 drops to RESET immediately and, after release, does a full 8-cycle HOLD.
REQ-038 SHALL verify that raw_i=4'b1111 at reset release gives level_o=4'b1111 after 6 edges, with four simultaneous rise_o pulses.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// Shared defaults and reset-sequencer state type for the board input conditioner.
package fpga_io_pkg;

    localparam int unsigned DEFAULT_NUM_INPUTS        = 12;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 20000;
    localparam int unsigned DEFAULT_RESET_HOLD_CYCLES = 1024;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } rst_state_e;

endpackage

// File: rtl/fpga_input_conditioner_if.sv
// Board-side bundle of the conditioner: raw pins and button in, debounced view and SoC reset out.
interface fpga_input_conditioner_if #(
    parameter int unsigned NUM_INPUTS = fpga_io_pkg::DEFAULT_NUM_INPUTS
);

    logic [NUM_INPUTS-1:0] raw;
    logic                  rst_btn;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] fall;
    logic                  soc_rst_n;

    modport master (output raw, rst_btn, input level, rise, fall, soc_rst_n);
    modport slave  (input raw, rst_btn, output level, rise, fall, soc_rst_n);

endinterface

// File: rtl/fpga_debounce_ch.sv
// One conditioned input: 2-flop synchronizer, stable-time counter, debounced level and edge pulses.
module fpga_debounce_ch
    import fpga_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_nxt,
    output logic rise,
    output logic fall
);
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          expire;

    assign mismatch  = (s2 != level);
    assign expire    = mismatch && (cnt == CNT_LAST);
    assign level_nxt = level ^ expire;

    // NOTE: non-blocking assignments so s1 and s2 really form two stages on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level_nxt;
            rise  <= expire && !level;
            fall  <= expire && level;
            if (!mismatch || expire) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga_input_conditioner.sv
// Conditions raw board pins and sequences the SoC reset from the pad reset
// and a debounced user reset button.
module fpga_input_conditioner
    import fpga_io_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = DEFAULT_NUM_INPUTS,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
    input  logic                  ref_clk_i,
    input  logic                  pad_reset,
    input  logic [NUM_INPUTS-1:0] raw_i,
    input  logic                  rst_btn_i,
    output logic [NUM_INPUTS-1:0] level_o,
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o,
    output logic                  soc_rst_no
);
    localparam int unsigned   HW        = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    logic [1:0]            rst_sync;
    logic                  rst;
    logic [NUM_INPUTS-1:0] unused_level_nxt;
    logic                  btn_level;
    logic                  btn_level_nxt;
    logic                  unused_btn_rise;
    logic                  unused_btn_fall;
    rst_state_e            state;
    rst_state_e            state_nxt;
    logic [HW-1:0]         hold_cnt;
    logic                  hold_done;

    // Pad reset asserts at once but is released only after two clean edges.
    always_ff @(posedge ref_clk_i or posedge pad_reset) begin
        if (pad_reset) rst_sync <= 2'b11;
        else           rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        fpga_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
            .clk      (ref_clk_i),
            .rst      (rst),
            .raw      (raw_i[i]),
            .level    (level_o[i]),
            .level_nxt(unused_level_nxt[i]),
            .rise     (rise_o[i]),
            .fall     (fall_o[i])
        );
    end

    fpga_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk      (ref_clk_i),
        .rst      (rst),
        .raw      (rst_btn_i),
        .level    (btn_level),
        .level_nxt(btn_level_nxt),
        .rise     (unused_btn_rise),
        .fall     (unused_btn_fall)
    );

    assign hold_done = (hold_cnt == HOLD_LAST);

    always_ff @(posedge ref_clk_i or posedge rst) begin
        if (rst) state <= RESET;
        else     state <= state_nxt;
    end

    // RUN reacts to the button level being latched this edge, so the SoC reset drops with it.
    // NOTE: default assignment first keeps this block purely combinational.
    always_comb begin
        state_nxt = state;
        case (state)
            RESET:   state_nxt = HOLD;
            HOLD:    if (!btn_level && hold_done) state_nxt = RUN;
            RUN:     if (btn_level_nxt) state_nxt = HOLD;
            default: state_nxt = RESET;
        endcase
    end

    always_comb begin
        soc_rst_no = (state == RUN);
    end

    // The hold count only advances while the debounced button is released.
    always_ff @(posedge ref_clk_i or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != HOLD || btn_level || hold_done) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule
